multicycle_alu: RTL
===================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand, immediate and result width in bits (legal range 4..32).
REQ-002 The block SHALL have parameter MUL_EN, default 1; when 1 opcode 0110 is a multiply, and when 0 it is illegal.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1 bit: the operation on opcode/a/b/immediate is presented.
REQ-006 Port in_ready, output, 1 bit: the block accepts an operation this cycle.
REQ-007 Port opcode, input, 4 bits: operation select.
REQ-008 Ports a, b and immediate, inputs, WIDTH bits each: operands.
REQ-009 Port out_valid, output, 1 bit: a one-cycle pulse marking alu_result and the flags as valid.
REQ-010 Port alu_result, output, WIDTH bits: the registered result.
REQ-011 Ports zero, negative, carry, overflow and illegal, outputs, 1 bit each: registered flags.

Function
REQ-012 An operation SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; inputs are captured at acceptance, and later input changes have no effect.
REQ-013 in_ready SHALL be 1 in IDLE only, and 0 in MUL and DONE.
REQ-014 The opcode encodings SHALL be as follows:
- 0010 add: a+b
- 0011 sub: a-b
- 1010 addi: a+immediate
- 1011 subi: a-immediate
- 0100 and: a&b
- 0101 or: a|b
- 0110 mul: low WIDTH bits of a*b, unsigned
REQ-015 All other opcodes SHALL be illegal: alu_result=0, illegal=1, all other flags 0, with out_valid asserted on single-cycle timing.
REQ-016 The FSM SHALL have the states IDLE, MUL and DONE.
REQ-017 Transitions SHALL be IDLE->DONE on accepting a non-mul operation, IDLE->MUL on accepting a mul, MUL->DONE after WIDTH iterations, and DONE->IDLE unconditionally.
REQ-018 out_valid SHALL be 1 exactly during DONE; a single-cycle op therefore has latency 1 (acceptance edge to out_valid high) and a throughput of one op per 2 cycles.
REQ-019 Mul SHALL be computed shift-add, one multiplier bit per cycle, LSB first, with out_valid high WIDTH+1 cycles after acceptance.
REQ-020 alu_result and the flags SHALL hold their last values until the next DONE, and SHALL NOT be changed in IDLE or MUL.
REQ-021 zero SHALL be set when alu_result==0 for every legal opcode (the predecessor computed it for sub/subi only).
REQ-022 negative SHALL be alu_result[WIDTH-1] for every legal opcode.
REQ-023 For add/addi, carry SHALL be the carry-out of bit WIDTH-1, and overflow SHALL be signed two's-complement overflow.
REQ-024 For sub/subi, carry SHALL be 1 when a borrow occurs (a < operand, unsigned), and overflow SHALL be signed overflow.
REQ-025 For and/or, carry and overflow SHALL be 0.
REQ-026 For mul, carry SHALL be 0 and overflow SHALL be 1 when the upper WIDTH bits of the full 2*WIDTH product are non-zero.
REQ-027 illegal SHALL be 0 for every legal opcode.
REQ-028 Arithmetic SHALL wrap modulo 2^WIDTH with no saturation.
REQ-029 in_valid asserted while in_ready=0 SHALL be ignored: no capture and no state change; the source must hold the request until acceptance.
REQ-030 An operand of 0 to mul SHALL still take the full WIDTH+1 cycle latency, with no early termination.

Reset
REQ-031 While rst=1 the state SHALL be IDLE, and out_valid, alu_result, zero, negative, carry, overflow and illegal SHALL all be 0.
REQ-032 in_ready SHALL be 0 while rst=1, and SHALL be 1 from the first clk edge after rst is released.
REQ-033 Assertion of rst during MUL or DONE SHALL abort immediately: there is no out_valid for the aborted op and the partial product is discarded.

Verification
REQ-034 WIDTH=16, add a=0xFFFF b=0x0001 -> 1 cycle later out_valid=1, alu_result=0x0000, zero=1, carry=1, overflow=0.
REQ-035 WIDTH=16, subi a=0x8000 immediate=0x0001 -> alu_result=0x7FFF, overflow=1, carry=0, negative=0.
REQ-036 WIDTH=16, mul a=0x0100 b=0x0101 -> out_valid exactly 17 cycles after acceptance, alu_result=0x0100, overflow=1; in_ready=0 throughout, and a second request held during MUL is accepted only after DONE.
REQ-037 opcode=1111 -> 1 cycle later out_valid=1, alu_result=0, illegal=1; the next legal op clears illegal.
REQ-038 Reset mid-mul: rst pulsed 5 cycles after mul acceptance -> all outputs 0 immediately, no out_valid, in_ready=1 after release.
REQ-039 WIDTH=8 regression: and a=0xF0 b=0x3C -> 0x30; mul 0x0F*0x11 -> 0xFF, overflow=0, latency 9 cycles.

Source files
------------

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle add/sub/logic ops and a shift-add multiplier
// sharing a valid/ready request port and a registered result with flags.
module multicycle_alu #(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] immediate,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b1010;
    localparam logic [3:0] OP_SUBI = 4'b1011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_MUL  = 4'b0110;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t               state_q, state_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     alu_result_q, alu_result_d;
    logic                 zero_q, zero_d;
    logic                 negative_q, negative_d;
    logic                 carry_q, carry_d;
    logic                 overflow_q, overflow_d;
    logic                 illegal_q, illegal_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic [WIDTH-1:0]     opnd;
    logic [WIDTH:0]       sum_w, diff_w, step_w;
    logic [WIDTH-1:0]     res;
    logic                 res_c, res_v, res_ill, res_wr;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d      = state_q;
        alu_result_d = alu_result_q;
        zero_d       = zero_q;
        negative_d   = negative_q;
        carry_d      = carry_q;
        overflow_d   = overflow_q;
        illegal_d    = illegal_q;
        mcand_d      = mcand_q;
        prod_d       = prod_q;
        cnt_d        = cnt_q;
        res          = '0;
        res_c        = 1'b0;
        res_v        = 1'b0;
        res_ill      = 1'b0;
        res_wr       = 1'b0;

        opnd   = opcode[3] ? immediate : b;
        sum_w  = {1'b0, a} + {1'b0, opnd};
        diff_w = {1'b0, a} - {1'b0, opnd};
        // One shift-add step: add the multiplicand into the upper half when the current multiplier bit is set.
        step_w = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d = DONE;
                    res_wr  = 1'b1;
                    case (opcode)
                        OP_ADD, OP_ADDI: begin
                            res   = sum_w[WIDTH-1:0];
                            res_c = sum_w[WIDTH];
                            res_v = (a[WIDTH-1] == opnd[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
                        end
                        OP_SUB, OP_SUBI: begin
                            res   = diff_w[WIDTH-1:0];
                            res_c = diff_w[WIDTH];
                            res_v = (a[WIDTH-1] != opnd[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
                        end
                        OP_AND: res = a & b;
                        OP_OR:  res = a | b;
                        OP_MUL: begin
                            if (MUL_EN) begin
                                state_d = MUL;
                                res_wr  = 1'b0;
                                mcand_d = a;
                                prod_d  = {{WIDTH{1'b0}}, b};
                                cnt_d   = '0;
                            end else begin
                                res_ill = 1'b1;
                            end
                        end
                        default: res_ill = 1'b1;
                    endcase
                end
            end
            MUL: begin
                prod_d = {step_w, prod_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    res_wr  = 1'b1;
                    res     = prod_d[WIDTH-1:0];
                    res_v   = |prod_d[2*WIDTH-1:WIDTH];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (res_wr) begin
            alu_result_d = res;
            zero_d       = !res_ill && (res == '0);
            negative_d   = res[WIDTH-1];
            carry_d      = res_c;
            overflow_d   = res_v;
            illegal_d    = res_ill;
        end

        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            alu_result_q <= '0;
            zero_q       <= 1'b0;
            negative_q   <= 1'b0;
            carry_q      <= 1'b0;
            overflow_q   <= 1'b0;
            illegal_q    <= 1'b0;
            mcand_q      <= '0;
            prod_q       <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            alu_result_q <= alu_result_d;
            zero_q       <= zero_d;
            negative_q   <= negative_d;
            carry_q      <= carry_d;
            overflow_q   <= overflow_d;
            illegal_q    <= illegal_d;
            mcand_q      <= mcand_d;
            prod_q       <= prod_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign alu_result = alu_result_q;
    assign zero       = zero_q;
    assign negative   = negative_q;
    assign carry      = carry_q;
    assign overflow   = overflow_q;
    assign illegal    = illegal_q;

endmodule
